// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU control sequencer.
package cpu_pkg;

    localparam int unsigned INST_W       = 32;
    localparam int unsigned OP_W         = 3;
    localparam int unsigned REG_W        = 5;
    localparam int unsigned R3_W         = 3;
    localparam int unsigned ADDR_FIELD_W = 16;

    // Instruction field positions (LSB of each field)
    localparam int unsigned OP_LSB   = 29;
    localparam int unsigned R1_LSB   = 24;
    localparam int unsigned R2_LSB   = 19;
    localparam int unsigned R3_LSB   = 16;
    localparam int unsigned ADDR_LSB = 0;

    localparam logic [OP_W-1:0] OP_NOP  = 3'b000;
    localparam logic [OP_W-1:0] OP_LW   = 3'b001;
    localparam logic [OP_W-1:0] OP_SW   = 3'b010;
    localparam logic [OP_W-1:0] OP_BEQ  = 3'b011;
    localparam logic [OP_W-1:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_t;

    // True for every opcode the sequencer knows how to execute
    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        return (op == OP_NOP) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_HALT);
    endfunction

endpackage

// File: rtl/cpu_pc_unit.sv
// Program counter: sequential increment or BEQ target, both wrapping at PC_W.
module cpu_pc_unit
    import cpu_pkg::*;
#(
    parameter int unsigned     PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    inc,
    input  logic                    branch,
    input  logic [ADDR_FIELD_W-1:0] offset,
    output logic [PC_W-1:0]         pc
);

    logic [PC_W-1:0] pc_plus1;
    logic [PC_W-1:0] br_target;

    // Both candidates are computed modulo 2^PC_W so wrap falls out naturally
    always_comb begin
        pc_plus1  = pc + PC_W'(1);
        br_target = pc_plus1 + PC_W'($signed(offset));
    end

    // PC register; branch has priority over a plain increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (branch) begin
            pc <= br_target;
        end else if (inc) begin
            pc <= pc_plus1;
        end
    end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle fetch/decode/memory/writeback sequencer for the 3-bit-opcode CPU.
module cpu_seq_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned     PC_W     = 16,
    parameter int unsigned     DADDR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INST_W-1:0]  imem_rdata,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DADDR_W-1:0] dmem_addr,
    output logic [31:0]        dmem_wdata,
    input  logic               dmem_ack,
    input  logic [31:0]        dmem_rdata,
    output logic [REG_W-1:0]   rf_raddr1,
    output logic [REG_W-1:0]   rf_raddr2,
    input  logic [31:0]        rf_rdata1,
    input  logic [31:0]        rf_rdata2,
    output logic               rf_we,
    output logic [REG_W-1:0]   rf_waddr,
    output logic [31:0]        rf_wdata,
    output logic [PC_W-1:0]    pc,
    output logic               busy,
    output logic               halted,
    output logic               illegal
);

    state_t              state;
    state_t              state_next;
    logic [INST_W-1:0]   ir;
    logic [31:0]         ld_data;
    logic [OP_W-1:0]     op;
    logic                ops_equal;
    logic                pc_inc;
    logic                pc_branch;
    logic                ir_load;
    logic                ld_capture;
    logic                set_illegal;
    logic                unused_rsvd;

    assign op          = ir[OP_LSB +: OP_W];
    assign ops_equal   = (rf_rdata1 == rf_rdata2);
    assign unused_rsvd = ^ir[R3_LSB +: R3_W];

    // Datapath fields come straight from the IR; the FSM only gates the strobes
    assign imem_addr  = pc;
    assign rf_raddr1  = ir[R1_LSB +: REG_W];
    assign rf_raddr2  = ir[R2_LSB +: REG_W];
    assign rf_waddr   = ir[R1_LSB +: REG_W];
    assign rf_wdata   = ld_data;
    assign dmem_addr  = ir[ADDR_LSB +: DADDR_W];
    assign dmem_wdata = rf_rdata1;

    cpu_pc_unit #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk    (clk),
        .rst    (rst),
        .inc    (pc_inc),
        .branch (pc_branch),
        .offset (ir[ADDR_LSB +: ADDR_FIELD_W]),
        .pc     (pc)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start) state_next = ST_FETCH;
            ST_FETCH:  if (imem_ack) state_next = ST_DECODE;
            ST_DECODE: begin
                if (!op_is_legal(op) || (op == OP_HALT)) begin
                    state_next = ST_HALT;
                end else if ((op == OP_LW) || (op == OP_SW)) begin
                    state_next = ST_MEM;
                end else begin
                    state_next = ST_FETCH;
                end
            end
            ST_MEM: begin
                if (dmem_ack) state_next = (op == OP_LW) ? ST_WB : ST_FETCH;
            end
            ST_WB:     state_next = ST_FETCH;
            ST_HALT:   if (start) state_next = ST_FETCH;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Output and control-strobe decode
    always_comb begin
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        rf_we       = 1'b0;
        busy        = 1'b0;
        halted      = 1'b0;
        pc_inc      = 1'b0;
        pc_branch   = 1'b0;
        ir_load     = 1'b0;
        ld_capture  = 1'b0;
        set_illegal = 1'b0;
        case (state)
            ST_FETCH: begin
                busy     = 1'b1;
                imem_req = 1'b1;
                ir_load  = imem_ack;
            end
            ST_DECODE: begin
                busy = 1'b1;
                if (!op_is_legal(op)) begin
                    set_illegal = 1'b1;
                end else if (op == OP_NOP) begin
                    pc_inc = 1'b1;
                end else if (op == OP_BEQ) begin
                    pc_branch = ops_equal;
                    pc_inc    = !ops_equal;
                end
            end
            ST_MEM: begin
                busy       = 1'b1;
                dmem_req   = 1'b1;
                dmem_we    = (op == OP_SW);
                ld_capture = dmem_ack && (op == OP_LW);
                pc_inc     = dmem_ack && (op == OP_SW);
            end
            ST_WB: begin
                busy   = 1'b1;
                rf_we  = 1'b1;
                pc_inc = 1'b1;
            end
            ST_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    // Instruction register, load-data capture and sticky illegal flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir      <= '0;
            ld_data <= '0;
            illegal <= 1'b0;
        end else begin
            if (ir_load)     ir      <= imem_rdata;
            if (ld_capture)  ld_data <= dmem_rdata;
            if (set_illegal) illegal <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Scoreboard bench for cpu_seq_ctrl: directed programs, queued expected bus events.
module tb_cpu_seq_ctrl;
    import cpu_pkg::*;

    localparam int unsigned PC_W    = 16;
    localparam int unsigned DADDR_W = 16;

    logic               clk;
    logic               rst;
    logic               start;
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack;
    logic [31:0]        imem_rdata;
    logic               dmem_req;
    logic               dmem_we;
    logic [DADDR_W-1:0] dmem_addr;
    logic [31:0]        dmem_wdata;
    logic               dmem_ack;
    logic [31:0]        dmem_rdata;
    logic [4:0]         rf_raddr1;
    logic [4:0]         rf_raddr2;
    logic [31:0]        rf_rdata1;
    logic [31:0]        rf_rdata2;
    logic               rf_we;
    logic [4:0]         rf_waddr;
    logic [31:0]        rf_wdata;
    logic [PC_W-1:0]    pc;
    logic               busy;
    logic               halted;
    logic               illegal;

    logic iack_resp, iack_force;
    assign imem_ack = iack_resp | iack_force;

    logic [31:0] rf_model [32];
    assign rf_rdata1 = rf_model[rf_raddr1];
    assign rf_rdata2 = rf_model[rf_raddr2];

    logic [31:0] imem [logic [15:0]];
    logic [31:0] dram [logic [15:0]];
    int imem_wait, dmem_wait;

    int checks, errors;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
    } dtx_t;
    typedef struct packed {
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } rfw_t;

    logic [15:0] exp_fetch [$];
    dtx_t        exp_dmem  [$];
    rfw_t        exp_rf    [$];

    cpu_seq_ctrl #(.PC_W(PC_W), .DADDR_W(DADDR_W), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .pc(pc), .busy(busy), .halted(halted), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_event(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event not expected or never arrived", name);
    endtask

    function automatic logic [31:0] enc(input logic [2:0] op, input logic [4:0] r1,
                                        input logic [4:0] r2, input logic [15:0] a);
        return {op, r1, r2, 3'b000, a};
    endfunction

    // Instruction memory responder with programmable wait states
    initial begin
        int icnt;
        icnt = 0;
        iack_resp = 1'b0;
        imem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (imem_req) begin
                if (icnt >= imem_wait) begin
                    iack_resp  = 1'b1;
                    imem_rdata = imem.exists(imem_addr) ? imem[imem_addr] : 32'h0;
                    icnt = 0;
                end else begin
                    iack_resp = 1'b0;
                    icnt++;
                end
            end else begin
                iack_resp = 1'b0;
                icnt = 0;
            end
        end
    end

    // Data memory responder with programmable wait states
    initial begin
        int dcnt;
        dcnt = 0;
        dmem_ack = 1'b0;
        dmem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (dmem_req) begin
                if (dcnt >= dmem_wait) begin
                    dmem_ack = 1'b1;
                    if (dmem_we) dram[dmem_addr] = dmem_wdata;
                    else dmem_rdata = dram.exists(dmem_addr) ? dram[dmem_addr] : 32'h0;
                    dcnt = 0;
                end else begin
                    dmem_ack = 1'b0;
                    dcnt++;
                end
            end else begin
                dmem_ack = 1'b0;
                dcnt = 0;
            end
        end
    end

    // Monitor: pops expected events when the DUT completes a transfer
    logic        i_pend, d_pend;
    logic [15:0] i_snap;
    dtx_t        d_snap;
    initial begin
        i_pend = 1'b0;
        d_pend = 1'b0;
        i_snap = '0;
        d_snap = '0;
    end
    always @(negedge clk) begin
        dtx_t e;
        rfw_t w;
        if (imem_req || dmem_req) check("req_exclusive", imem_req & dmem_req, 0);
        if (imem_req && i_pend) check("imem_addr_stable", imem_addr, i_snap);
        if (dmem_req && d_pend) check("dmem_stable", {dmem_we, dmem_addr, dmem_wdata}, d_snap);
        if (imem_req && imem_ack) begin
            if (exp_fetch.size() == 0) fail_event("fetch_unexpected");
            else check("fetch_addr", imem_addr, exp_fetch.pop_front());
        end
        if (dmem_req && dmem_ack) begin
            if (exp_dmem.size() == 0) fail_event("dmem_unexpected");
            else begin
                e = exp_dmem.pop_front();
                check("dmem_we", dmem_we, e.we);
                check("dmem_addr", dmem_addr, e.addr);
                if (e.we) check("dmem_wdata", dmem_wdata, e.wdata);
            end
        end
        if (rf_we) begin
            if (exp_rf.size() == 0) fail_event("rf_we_unexpected");
            else begin
                w = exp_rf.pop_front();
                check("rf_waddr", rf_waddr, w.waddr);
                check("rf_wdata", rf_wdata, w.wdata);
            end
        end
        i_pend = imem_req && !imem_ack;
        i_snap = imem_addr;
        d_pend = dmem_req && !dmem_ack;
        d_snap = {dmem_we, dmem_addr, dmem_wdata};
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic do_reset();
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_halt(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!halted && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!halted) fail_event(name);
    endtask

    task automatic wait_pc(input logic [15:0] v, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (pc !== v && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (pc !== v) fail_event(name);
    endtask

    task automatic wait_leave(input logic [15:0] v, output logic [15:0] got);
        int n;
        n = 0;
        @(negedge clk);
        while (pc === v && n < 300) begin
            @(negedge clk);
            n++;
        end
        got = pc;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] got;
        int req_cycles;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        start = 1'b0;
        iack_force = 1'b0;
        imem_wait = 0;
        dmem_wait = 0;
        for (int i = 0; i < 32; i++) rf_model[i] = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_pc", pc, 16'h0000);
        check("rst_imem_req", imem_req, 0);
        check("rst_dmem_req", dmem_req, 0);
        check("rst_rf_we", rf_we, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_illegal", illegal, 0);

        // LW r3,0x10 ; NOP ; HALT with zero-wait acks
        imem[16'h0000] = enc(OP_LW, 5'd3, 5'd0, 16'h0010);
        imem[16'h0001] = 32'h0;
        imem[16'h0002] = enc(OP_HALT, 5'd0, 5'd0, 16'h0);
        dram[16'h0010] = 32'hDEADBEEF;
        exp_fetch.push_back(16'h0000);
        exp_fetch.push_back(16'h0001);
        exp_fetch.push_back(16'h0002);
        exp_dmem.push_back('{we: 1'b0, addr: 16'h0010, wdata: 32'h0});
        exp_rf.push_back('{waddr: 5'd3, wdata: 32'hDEADBEEF});
        pulse_start();
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check($sformatf("lw_rf_we_cycle%0d", i), rf_we, (i == 4));
        end
        wait_halt("lw_halt_timeout");
        check("lw_pc_after_nop", pc, 16'h0002);
        check("lw_halted", halted, 1);
        check("lw_busy", busy, 0);

        // SW r5 -> 0x20 with three data wait states
        do_reset();
        imem.delete();
        imem[16'h0000] = enc(OP_SW, 5'd5, 5'd0, 16'h0020);
        imem[16'h0001] = enc(OP_HALT, 5'd0, 5'd0, 16'h0);
        rf_model[5] = 32'h12345678;
        dmem_wait = 3;
        exp_fetch.push_back(16'h0000);
        exp_fetch.push_back(16'h0001);
        exp_dmem.push_back('{we: 1'b1, addr: 16'h0020, wdata: 32'h12345678});
        pulse_start();
        req_cycles = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (dmem_req) req_cycles++;
            if (halted) break;
        end
        check("sw_halted", halted, 1);
        check("sw_req_cycles", req_cycles, 4);
        check("sw_pc", pc, 16'h0001);
        check("sw_ram", dram.exists(16'h0020) ? dram[16'h0020] : 32'h0, 32'h12345678);
        dmem_wait = 0;

        // BEQ at pc 5: taken back to 4, then not taken to 6
        do_reset();
        imem.delete();
        imem[16'h0005] = enc(OP_BEQ, 5'd1, 5'd2, 16'hFFFE);
        imem[16'h0006] = enc(OP_HALT, 5'd0, 5'd0, 16'h0);
        rf_model[1] = 32'hAAAA5555;
        rf_model[2] = 32'hAAAA5555;
        for (int a = 0; a <= 5; a++) exp_fetch.push_back(16'(a));
        exp_fetch.push_back(16'h0004);
        exp_fetch.push_back(16'h0005);
        exp_fetch.push_back(16'h0006);
        pulse_start();
        wait_pc(16'h0005, "beq_reach5_timeout");
        wait_leave(16'h0005, got);
        check("beq_taken_pc", got, 16'h0004);
        rf_model[2] = 32'h5555AAAA;
        wait_pc(16'h0005, "beq_reach5b_timeout");
        wait_leave(16'h0005, got);
        check("beq_not_taken_pc", got, 16'h0006);
        wait_halt("beq_halt_timeout");
        check("beq_final_pc", pc, 16'h0006);

        // Illegal opcode 101 at pc 3, then restart re-fetches pc 3
        do_reset();
        imem.delete();
        imem[16'h0003] = enc(3'b101, 5'd0, 5'd0, 16'h0);
        for (int a = 0; a <= 3; a++) exp_fetch.push_back(16'(a));
        pulse_start();
        wait_halt("ill_halt_timeout");
        check("ill_flag", illegal, 1);
        check("ill_halted", halted, 1);
        check("ill_pc", pc, 16'h0003);
        exp_fetch.push_back(16'h0003);
        pulse_start();
        check("ill_restart_busy", busy, 1);
        wait_halt("ill_rehalt_timeout");
        check("ill_restart_pc", pc, 16'h0003);
        check("ill_sticky", illegal, 1);

        // Async reset mid-FETCH, then a stray ack
        imem_wait = 10;
        pulse_start();
        @(negedge clk);
        check("midfetch_req", imem_req, 1);
        #1 rst = 1'b1;
        #1;
        check("async_req_drop", imem_req, 0);
        check("async_pc", pc, 16'h0000);
        check("async_busy", busy, 0);
        @(posedge clk); #1 rst = 1'b0;
        iack_force = 1'b1;
        @(posedge clk); #1 iack_force = 1'b0;
        @(negedge clk);
        check("stray_busy", busy, 0);
        check("stray_req", imem_req, 0);
        check("stray_pc", pc, 16'h0000);
        check("stray_illegal_cleared", illegal, 0);
        repeat (3) @(negedge clk);
        check("stray_idle", busy | halted, 0);
        imem_wait = 0;

        // Wrap: branch to 0xFFFF, NOP wraps to 0; start while busy is ignored
        imem.delete();
        imem[16'h0000] = enc(OP_BEQ, 5'd1, 5'd2, 16'hFFFE);
        imem[16'hFFFF] = 32'h0;
        rf_model[1] = 32'h0F0F0F0F;
        rf_model[2] = 32'h0F0F0F0F;
        exp_fetch.push_back(16'h0000);
        exp_fetch.push_back(16'hFFFF);
        exp_fetch.push_back(16'h0000);
        pulse_start();
        @(posedge clk); #1 start = 1'b1;
        check("busy_start_busy", busy, 1);
        @(posedge clk); #1 start = 1'b0;
        wait_pc(16'hFFFF, "wrap_reach_timeout");
        imem[16'h0000] = enc(OP_HALT, 5'd0, 5'd0, 16'h0);
        wait_leave(16'hFFFF, got);
        check("wrap_pc", got, 16'h0000);
        wait_halt("wrap_halt_timeout");
        check("wrap_final_pc", pc, 16'h0000);

        repeat (2) @(negedge clk);
        check("fetch_queue_drained", exp_fetch.size(), 0);
        check("dmem_queue_drained", exp_dmem.size(), 0);
        check("rf_queue_drained", exp_rf.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
